// File: rtl/lock_controller.sv
// lock_controller: sequencing FSM for a 4-digit hex combination lock with password set/change.
// Optional failed-attempt lockout state and timer are built when LOCK_LOCKOUT_EN is defined.
module lock_controller #(
    parameter logic [15:0] DEFAULT_PW     = 16'hFFFF,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  hex_in,
    input  logic        enter,
    input  logic        set,
    input  logic        change,
    output logic [15:0] current_password,
    output logic [15:0] entry_digits,
    output logic [2:0]  digit_cnt,
    output logic [2:0]  state,
    output logic        unlocked,
    output logic        locked_out,
    output logic [2:0]  fail_cnt,
    output logic        pw_updated
);

    typedef enum logic [2:0] {
        ST_LOCKED   = 3'd0,
        ST_CHECK    = 3'd1,
        ST_UNLOCKED = 3'd2,
        ST_SET_NEW  = 3'd3
`ifdef LOCK_LOCKOUT_EN
        ,ST_LOCKOUT = 3'd4
`endif
    } state_t;

    if (MAX_FAILS < 1 || MAX_FAILS > 7) begin : g_bad_max_fails
        $error("lock_controller: MAX_FAILS must be in 1..7");
    end
    if (LOCKOUT_CYCLES < 1) begin : g_bad_lockout_cycles
        $error("lock_controller: LOCKOUT_CYCLES must be at least 1");
    end

    state_t      state_q;
    logic [15:0] pw_q;
    logic [15:0] entry_q;
    logic [2:0]  cnt_q;
    logic [2:0]  fail_q;
    logic        pw_updated_q;
    logic        unlocked_q;
    logic        enter_prev_q;
    logic        set_prev_q;
    logic        change_prev_q;

`ifdef LOCK_LOCKOUT_EN
    localparam int unsigned        TIMER_W     = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]         MAX_FAILS_C = 3'(MAX_FAILS);

    logic [TIMER_W-1:0] timer_q;
    logic               locked_out_q;
`endif

    // Buttons are levels; only a rising edge acts, and when several rise together the
    // acting priority within a state is change > set > enter (the loser is dropped).
    logic        enter_rise;
    logic        set_rise;
    logic        change_rise;
    logic [15:0] entry_shifted;
    logic [2:0]  fail_inc;

    assign enter_rise    = enter & ~enter_prev_q;
    assign set_rise      = set & ~set_prev_q;
    assign change_rise   = change & ~change_prev_q;
    assign entry_shifted = {entry_q[11:0], hex_in};
    assign fail_inc      = (fail_q == 3'd7) ? 3'd7 : fail_q + 3'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_LOCKED;
            pw_q          <= DEFAULT_PW;
            entry_q       <= '0;
            cnt_q         <= '0;
            fail_q        <= '0;
            pw_updated_q  <= 1'b0;
            unlocked_q    <= 1'b0;
            enter_prev_q  <= 1'b0;
            set_prev_q    <= 1'b0;
            change_prev_q <= 1'b0;
`ifdef LOCK_LOCKOUT_EN
            timer_q       <= '0;
            locked_out_q  <= 1'b0;
`endif
        end else begin
            enter_prev_q  <= enter;
            set_prev_q    <= set;
            change_prev_q <= change;
            pw_updated_q  <= 1'b0;

            case (state_q)
                ST_LOCKED: begin
                    if (enter_rise) begin
                        entry_q <= entry_shifted;
                        cnt_q   <= cnt_q + 3'd1;
                        if (cnt_q == 3'd3) begin
                            state_q <= ST_CHECK;
                        end
                    end
                end

                ST_CHECK: begin
                    entry_q <= '0;
                    cnt_q   <= '0;
                    if (entry_q == pw_q) begin
                        state_q    <= ST_UNLOCKED;
                        unlocked_q <= 1'b1;
                        fail_q     <= '0;
                    end else begin
                        fail_q <= fail_inc;
`ifdef LOCK_LOCKOUT_EN
                        if (fail_inc >= MAX_FAILS_C) begin
                            state_q      <= ST_LOCKOUT;
                            locked_out_q <= 1'b1;
                        end else begin
                            state_q <= ST_LOCKED;
                        end
`else
                        state_q <= ST_LOCKED;
`endif
                    end
                end

                ST_UNLOCKED: begin
                    if (change_rise) begin
                        state_q    <= ST_LOCKED;
                        unlocked_q <= 1'b0;
                    end else if (set_rise) begin
                        state_q <= ST_SET_NEW;
                        entry_q <= '0;
                        cnt_q   <= '0;
                    end
                end

                ST_SET_NEW: begin
                    if (change_rise) begin
                        state_q <= ST_UNLOCKED;
                        entry_q <= '0;
                        cnt_q   <= '0;
                    end else if (enter_rise) begin
                        if (cnt_q == 3'd3) begin
                            // Fourth digit commits the new password on this same edge.
                            pw_q         <= entry_shifted;
                            pw_updated_q <= 1'b1;
                            state_q      <= ST_LOCKED;
                            unlocked_q   <= 1'b0;
                            entry_q      <= '0;
                            cnt_q        <= '0;
                        end else begin
                            entry_q <= entry_shifted;
                            cnt_q   <= cnt_q + 3'd1;
                        end
                    end
                end

`ifdef LOCK_LOCKOUT_EN
                ST_LOCKOUT: begin
                    if (timer_q == TIMER_LAST) begin
                        state_q      <= ST_LOCKED;
                        locked_out_q <= 1'b0;
                        fail_q       <= '0;
                        timer_q      <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
`endif

                default: begin
                    state_q    <= ST_LOCKED;
                    unlocked_q <= 1'b0;
                    entry_q    <= '0;
                    cnt_q      <= '0;
                end
            endcase
        end
    end

    assign current_password = pw_q;
    assign entry_digits     = entry_q;
    assign digit_cnt        = cnt_q;
    assign state            = state_q;
    assign unlocked         = unlocked_q;
    assign fail_cnt         = fail_q;
    assign pw_updated       = pw_updated_q;
`ifdef LOCK_LOCKOUT_EN
    assign locked_out       = locked_out_q;
`else
    assign locked_out       = 1'b0;
`endif

endmodule

// File: tb/tb_lock_controller.sv
// tb_lock_controller: directed scenarios for lock_controller; every change of the output
// bundle is matched in order against hand-computed expected snapshots.
module tb_lock_controller;

    localparam int W = 52;

    localparam logic [2:0] S_LOCKED = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_UNL    = 3'd2;
    localparam logic [2:0] S_SET    = 3'd3;
    localparam logic [2:0] S_LOUT   = 3'd4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  hex_in;
    logic        enter;
    logic        set;
    logic        change;
    logic [15:0] current_password;
    logic [15:0] entry_digits;
    logic [2:0]  digit_cnt;
    logic [2:0]  state;
    logic        unlocked;
    logic        locked_out;
    logic [2:0]  fail_cnt;
    logic        pw_updated;

    int checks = 0;
    int errors = 0;

    // Entry layout: {gap[7:0], state, unlocked, locked_out, fail_cnt, pw_updated,
    // digit_cnt, entry_digits, current_password}; gap==0 means the timing is not checked.
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    lock_controller dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .hex_in           (hex_in),
        .enter            (enter),
        .set              (set),
        .change           (change),
        .current_password (current_password),
        .entry_digits     (entry_digits),
        .digit_cnt        (digit_cnt),
        .state            (state),
        .unlocked         (unlocked),
        .locked_out       (locked_out),
        .fail_cnt         (fail_cnt),
        .pw_updated       (pw_updated)
    );

    function automatic logic [W-1:0] snap_exp(input logic [2:0] st, input logic [2:0] fc,
                                              input logic pu, input logic [2:0] cnt,
                                              input logic [15:0] entry, input logic [15:0] pw,
                                              input logic [7:0] gap);
        logic ul;
        logic lo;
        ul = (st == S_UNL) || (st == S_SET);
        lo = (st == S_LOUT);
        return {gap, st, ul, lo, fc, pu, cnt, entry, pw};
    endfunction

    task automatic push(input logic [2:0] st, input logic [2:0] fc, input logic pu,
                        input logic [2:0] cnt, input logic [15:0] entry,
                        input logic [15:0] pw, input logic [7:0] gap);
        exp_q.push_back(snap_exp(st, fc, pu, cnt, entry, pw, gap));
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [43:0]  prev;
        logic [43:0]  cur;
        logic [W-1:0] e;
        int           cyc;
        int           last;
        int           idx;
        bit           first;
        cyc   = 0;
        last  = 0;
        idx   = 0;
        first = 1'b1;
        prev  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            cur = {state, unlocked, locked_out, fail_cnt, pw_updated, digit_cnt,
                   entry_digits, current_password};
            if (first || cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got %h at cycle %0d, required no change", cur, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e[43:0] || (e[51:44] != 8'd0 && 8'(cyc - last) != e[51:44])) begin
                        errors++;
                        $display("FAIL snap_%0d: got %h gap %0d, required %h gap %0d",
                                 idx, cur, cyc - last, e[43:0], e[51:44]);
                    end
                end
                idx++;
                prev  = cur;
                last  = cyc;
                first = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        tick();
        hex_in = d;
        enter  = 1'b1;
        tick();
        enter  = 1'b0;
        tick();
    endtask

    task automatic pulse_set();
        tick();
        set = 1'b1;
        tick();
        set = 1'b0;
        tick();
    endtask

    task automatic pulse_change();
        tick();
        change = 1'b1;
        tick();
        change = 1'b0;
        tick();
    endtask

    task automatic digits3(input logic [15:0] code, input logic [2:0] st,
                           input logic [2:0] fc, input logic [15:0] pw);
        for (int i = 0; i < 3; i++) begin
            logic [15:0] part;
            part = code >> (4 * (3 - i));
            push(st, fc, 1'b0, 3'(i + 1), part, pw, 8'd0);
            press(code[15 - 4 * i -: 4]);
        end
    endtask

    task automatic guess(input logic [15:0] code, input logic [2:0] fc, input logic [15:0] pw,
                         input logic [2:0] v_st, input logic [2:0] v_fc);
        digits3(code, S_LOCKED, fc, pw);
        push(S_CHECK, fc, 1'b0, 3'd4, code, pw, 8'd0);
        push(v_st, v_fc, 1'b0, 3'd0, 16'h0000, pw, 8'd1);
        press(code[3:0]);
    endtask

    task automatic set_pw(input logic [15:0] code, input logic [15:0] old_pw);
        digits3(code, S_SET, 3'd0, old_pw);
        push(S_LOCKED, 3'd0, 1'b1, 3'd0, 16'h0000, code, 8'd0);
        push(S_LOCKED, 3'd0, 1'b0, 3'd0, 16'h0000, code, 8'd1);
        press(code[3:0]);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] fc_after;
        reset_n = 1'b0;
        hex_in  = 4'h0;
        enter   = 1'b0;
        set     = 1'b0;
        change  = 1'b0;
        push(S_LOCKED, 3'd0, 1'b0, 3'd0, 16'h0000, 16'hFFFF, 8'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        // Default password opens the lock; CHECK lasts exactly one cycle.
        guess(16'hFFFF, 3'd0, 16'hFFFF, S_UNL, 3'd0);

        // Set password 0000, then a wrong and a right guess.
        push(S_SET, 3'd0, 1'b0, 3'd0, 16'h0000, 16'hFFFF, 8'd0);
        pulse_set();
        set_pw(16'h0000, 16'hFFFF);
        guess(16'hFFFF, 3'd0, 16'h0000, S_LOCKED, 3'd1);
        guess(16'h0000, 3'd1, 16'h0000, S_UNL, 3'd0);

        // Abort a partial new password.
        push(S_SET, 3'd0, 1'b0, 3'd0, 16'h0000, 16'h0000, 8'd0);
        pulse_set();
        push(S_SET, 3'd0, 1'b0, 3'd1, 16'h0005, 16'h0000, 8'd0);
        press(4'h5);
        push(S_SET, 3'd0, 1'b0, 3'd2, 16'h0055, 16'h0000, 8'd0);
        press(4'h5);
        push(S_UNL, 3'd0, 1'b0, 3'd0, 16'h0000, 16'h0000, 8'd0);
        pulse_change();

        // Enter and change rising together: abort wins, no digit taken.
        push(S_SET, 3'd0, 1'b0, 3'd0, 16'h0000, 16'h0000, 8'd0);
        pulse_set();
        push(S_UNL, 3'd0, 1'b0, 3'd0, 16'h0000, 16'h0000, 8'd0);
        tick();
        hex_in = 4'h7;
        enter  = 1'b1;
        change = 1'b1;
        tick();
        enter  = 1'b0;
        change = 1'b0;
        tick();

        // Enter held high for 10 cycles yields one digit.
        push(S_SET, 3'd0, 1'b0, 3'd0, 16'h0000, 16'h0000, 8'd0);
        pulse_set();
        push(S_SET, 3'd0, 1'b0, 3'd1, 16'h0009, 16'h0000, 8'd0);
        tick();
        hex_in = 4'h9;
        enter  = 1'b1;
        repeat (10) tick();
        enter  = 1'b0;
        tick();
        push(S_UNL, 3'd0, 1'b0, 3'd0, 16'h0000, 16'h0000, 8'd0);
        pulse_change();

        // Password 5555, then reset in the middle of an entry.
        push(S_SET, 3'd0, 1'b0, 3'd0, 16'h0000, 16'h0000, 8'd0);
        pulse_set();
        set_pw(16'h5555, 16'h0000);
        push(S_LOCKED, 3'd0, 1'b0, 3'd1, 16'h0001, 16'h5555, 8'd0);
        press(4'h1);
        push(S_LOCKED, 3'd0, 1'b0, 3'd2, 16'h0012, 16'h5555, 8'd0);
        press(4'h2);
        push(S_LOCKED, 3'd0, 1'b0, 3'd0, 16'h0000, 16'hFFFF, 8'd0);
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // set and change have no effect while LOCKED.
        pulse_set();
        pulse_change();

        // Three wrong guesses.
        guess(16'hAAAA, 3'd0, 16'hFFFF, S_LOCKED, 3'd1);
        guess(16'hAAAA, 3'd1, 16'hFFFF, S_LOCKED, 3'd2);
`ifdef LOCK_LOCKOUT_EN
        guess(16'hAAAA, 3'd2, 16'hFFFF, S_LOUT, 3'd3);
        push(S_LOCKED, 3'd0, 1'b0, 3'd0, 16'h0000, 16'hFFFF, 8'd100);
        repeat (5) press(4'h1);
        wait_drain(200);
        fc_after = 3'd0;
`else
        guess(16'hAAAA, 3'd2, 16'hFFFF, S_LOCKED, 3'd3);
        fc_after = 3'd3;
`endif
        // A correct guess clears the failure count.
        guess(16'hFFFF, fc_after, 16'hFFFF, S_UNL, 3'd0);

        wait_drain(200);
        repeat (10) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending snapshots, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
